// File: rtl/uart_tx_ctrl.sv
// Memory-mapped UART transmit controller: snoops CPU stores into a byte FIFO and
// sequences the uart_tx start/ready handshake one byte at a time.
module uart_tx_ctrl #(
    parameter logic [11:0] DATA_ADDR   = 12'h801,
    parameter logic [11:0] STATUS_ADDR = 12'h800,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                     clock,
    input  logic                     n_rst,
    input  logic [11:0]              bus_addr,
    input  logic [15:0]              bus_wdata,
    input  logic                     bus_we,
    input  logic                     tx_ready,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic [15:0]              status,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StStart = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            overflow_q, overflow_d;
    logic [7:0]      mem_q [DEPTH];

    logic push_req, ctrl_req, full, push, pop, flush, busy;

    assign push_req = bus_we && (bus_addr == DATA_ADDR);
    assign ctrl_req = bus_we && (bus_addr == STATUS_ADDR);
    assign full     = (count_q == FullCount);
    // Full is judged on the pre-edge count, so a same-edge pop never rescues a push.
    assign push     = push_req && !full;
    assign pop      = (state_q == StIdle) && (count_q != '0) && tx_ready;
    assign flush    = ctrl_req && bus_wdata[1];

    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        case (state_q)
            StIdle: begin
                if (pop) begin
                    state_d    = StStart;
                    tx_start_d = 1'b1;
                    tx_data_d  = mem_q[rd_ptr_q];
                end
            end
            StStart: begin
                if (!tx_ready) begin
                    state_d    = StWait;
                    tx_start_d = 1'b0;
                end
            end
            StWait: begin
                if (tx_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d    = StIdle;
                tx_start_d = 1'b0;
            end
        endcase
    end

    // A flush discards queued entries only; the byte already in tx_data still goes out.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (!push && pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_comb begin
        overflow_d = overflow_q;
        if (ctrl_req && bus_wdata[0]) begin
            overflow_d = 1'b0;
        end
        if (push_req && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus_wdata[7:0];
        end
    end

    assign busy     = (state_q != StIdle) || (count_q != '0);
    assign status   = {12'b0, overflow_q, full, busy, !full};
    assign count    = count_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: register-level vector table plus handshake
// sequences against a simple uart_tx model.
module tb_uart_tx_ctrl;

    localparam int FRAME = 10;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        n_rst;
    logic [11:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic        tx_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] status;
    logic [3:0]  count;

    logic        uart_en;
    logic        force_ready;
    logic        model_ready;
    int          model_cnt;
    logic [7:0]  rx_q[$];

    int compared   = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    assign tx_ready = uart_en ? model_ready : force_ready;

    uart_tx_ctrl #(
        .DATA_ADDR  (12'h801),
        .STATUS_ADDR(12'h800),
        .DEPTH      (DEPTH)
    ) dut (
        .clock    (clock),
        .n_rst    (n_rst),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_we   (bus_we),
        .tx_ready (tx_ready),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .status   (status),
        .count    (count)
    );

    // uart_tx model: accepts a start on the falling edge, stays busy for FRAME cycles.
    always @(negedge clock) begin
        if (!n_rst) begin
            model_ready = 1'b1;
            model_cnt   = 0;
        end else if (uart_en) begin
            if (model_ready && tx_start) begin
                rx_q.push_back(tx_data);
                model_ready = 1'b0;
                model_cnt   = FRAME;
            end else if (!model_ready) begin
                model_cnt = model_cnt - 1;
                if (model_cnt == 0) model_ready = 1'b1;
            end
        end
    end

    typedef struct {
        logic [11:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic [15:0] exp_status;
        logic [3:0]  exp_count;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [11:0] a, input logic [15:0] d, input logic we);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = we;
    endtask

    task automatic idle_bus();
        drive(12'h000, 16'h0000, 1'b0);
    endtask

    task automatic wait_idle(input string name, input int limit);
        int n;
        n = 0;
        while (!(status == 16'h0001 && model_ready && !tx_start) && n < limit) begin
            tick();
            n++;
        end
        if (n >= limit) begin
            compared++;
            mismatched++;
            $display("FAIL %s: timeout after %0d cycles, status 0x%0h", name, n, status);
        end
    endtask

    initial begin
        int base, max_cnt, full_seen, exp_count, pushed, coinc, cnt_err;
        logic prev_ready, prev_start, do_push, popped;

        for (int i = 0; i < 8; i++) begin
            vecs[i] = '{12'h801, 16'(16'hA530 + i), 1'b1,
                        (i == 7) ? 16'h0006 : 16'h0003, 4'(i + 1)};
        end
        vecs[8]  = '{12'h801, 16'h0038, 1'b1, 16'h000E, 4'd8};
        vecs[9]  = '{12'h800, 16'h0001, 1'b1, 16'h0006, 4'd8};
        vecs[10] = '{12'h802, 16'h0003, 1'b1, 16'h0006, 4'd8};
        vecs[11] = '{12'h800, 16'h0003, 1'b0, 16'h0006, 4'd8};
        vecs[12] = '{12'h800, 16'h0002, 1'b1, 16'h0001, 4'd0};
        vecs[13] = '{12'h801, 16'h00AA, 1'b1, 16'h0003, 4'd1};
        vecs[14] = '{12'h801, 16'h00BB, 1'b1, 16'h0003, 4'd2};
        vecs[15] = '{12'h800, 16'h0003, 1'b1, 16'h0001, 4'd0};

        uart_en     = 1'b0;
        force_ready = 1'b0;
        idle_bus();
        n_rst = 1'b0;
        #12;
        check("reset status", status, 16'h0001);
        check("reset count", count, 0);
        check("reset tx_start", tx_start, 0);
        check("reset tx_data", tx_data, 8'h00);
        @(negedge clock);
        n_rst = 1'b1;
        tick();

        // Register-level table with the UART held busy so nothing is popped.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].we);
            tick();
            check($sformatf("vec%0d status", i), status, vecs[i].exp_status);
            check($sformatf("vec%0d count", i), count, vecs[i].exp_count);
            check($sformatf("vec%0d tx_start", i), tx_start, 0);
        end
        idle_bus();

        // Single byte from idle.
        force_ready = 1'b1;
        uart_en     = 1'b1;
        tick();
        base = rx_q.size();
        drive(12'h801, 16'hAB41, 1'b1);
        tick();
        check("single count after push", count, 1);
        check("single tx_start at push", tx_start, 0);
        idle_bus();
        tick();
        check("single tx_start after pop", tx_start, 1);
        check("single tx_data", tx_data, 8'h41);
        check("single count after pop", count, 0);
        wait_idle("single drain", 200);
        check("single frames", rx_q.size() - base, 1);
        if (rx_q.size() > base) check("single rx byte", rx_q[base], 8'h41);
        check("single final status", status, 16'h0001);
        check("single final count", count, 0);

        // Burst of 8 on consecutive cycles.
        base      = rx_q.size();
        max_cnt   = 0;
        full_seen = 0;
        for (int i = 0; i < 8; i++) begin
            drive(12'h801, 16'(16'h0030 + i), 1'b1);
            tick();
            if (int'(count) > max_cnt) max_cnt = int'(count);
            if (status[2]) full_seen++;
        end
        idle_bus();
        wait_idle("burst drain", 500);
        check("burst peak count", max_cnt, 7);
        check("burst full seen", full_seen, 0);
        check("burst frames", rx_q.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            if (rx_q.size() > base + i) check($sformatf("burst byte%0d", i), rx_q[base + i], 8'h30 + i);
        end
        check("burst overflow", status[3], 0);

        // Flush during the first frame.
        base = rx_q.size();
        for (int i = 0; i < 4; i++) begin
            drive(12'h801, 16'(16'h0050 + i), 1'b1);
            tick();
        end
        check("flush count before", count, 3);
        drive(12'h800, 16'h0002, 1'b1);
        tick();
        idle_bus();
        check("flush count after", count, 0);
        check("flush tx_data held", tx_data, 8'h50);
        wait_idle("flush drain", 200);
        for (int i = 0; i < 30; i++) tick();
        check("flush frames", rx_q.size() - base, 1);
        if (rx_q.size() > base) check("flush rx byte", rx_q[base], 8'h50);

        // Sustained traffic: pushes timed to land on pop edges, through pointer wrap.
        base       = rx_q.size();
        exp_count  = 0;
        pushed     = 0;
        coinc      = 0;
        cnt_err    = 0;
        prev_ready = tx_ready;
        prev_start = tx_start;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            do_push = (pushed < 20) && (exp_count < DEPTH) &&
                      ((tx_ready && !prev_ready) || exp_count < 2);
            if (do_push) drive(12'h801, 16'(16'h0060 + pushed), 1'b1);
            else idle_bus();
            prev_ready = tx_ready;
            tick();
            popped     = tx_start && !prev_start;
            prev_start = tx_start;
            if (do_push) pushed++;
            exp_count = exp_count + int'(do_push) - int'(popped);
            if (do_push && popped) coinc++;
            if (int'(count) != exp_count) cnt_err++;
            if (pushed == 20 && exp_count == 0) break;
        end
        idle_bus();
        wait_idle("wrap drain", 500);
        check("wrap count errors", cnt_err, 0);
        check("wrap pushed", pushed, 20);
        check("wrap coincident push/pop", coinc > 0, 1);
        check("wrap frames", rx_q.size() - base, 20);
        for (int i = 0; i < 20; i++) begin
            if (rx_q.size() > base + i) check($sformatf("wrap byte%0d", i), rx_q[base + i], 8'h60 + i);
        end

        // Asynchronous reset while in START.
        uart_en     = 1'b0;
        force_ready = 1'b1;
        drive(12'h801, 16'h0070, 1'b1);
        tick();
        drive(12'h801, 16'h0071, 1'b1);
        tick();
        idle_bus();
        check("pre-reset tx_start", tx_start, 1);
        check("pre-reset count", count, 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("async reset tx_start", tx_start, 0);
        check("async reset count", count, 0);
        check("async reset status", status, 16'h0001);
        check("async reset tx_data", tx_data, 8'h00);
        @(negedge clock);
        n_rst = 1'b1;
        tick();
        tick();
        check("post-reset tx_start", tx_start, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
